// File: rtl/fnorm32.sv
`default_nettype none
// ============================================================================
//  Module   : fnorm32
//  Purpose  : Three-stage normalize / round / pack pipeline that turns an
//             unnormalized sign-exponent-magnitude result into an IEEE-754
//             binary32 word with overflow, underflow and inexact flags.
//  Options  : FNORM32_SUBNORM_EN - when defined, tiny results are delivered
//             as subnormals instead of being flushed to signed zero.
//  Revision : 1.0 - initial release
// ============================================================================
module fnorm32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [27:0] in_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
);

  localparam logic signed [10:0] c_exp_inf  = 11'sd255;
  localparam logic signed [10:0] c_exp_zero = 11'sd0;
  localparam logic signed [10:0] c_exp_one  = 11'sd1;

  // --------------------------------------------------------------------------
  // Global pipeline enable: every stage moves together whenever the output
  // register is empty or being drained this cycle.
  // --------------------------------------------------------------------------
  logic w_advance;
  logic r_out_vld;

  assign w_advance = !r_out_vld || out_ready;
  assign in_ready  = w_advance;

  // --------------------------------------------------------------------------
  // Stage 1 : normalize so that the hidden bit sits at bit 26
  // --------------------------------------------------------------------------
  logic signed [10:0] w_in_exp_x;
  logic [4:0]         w_lz;
  logic [26:0]        w_n1_man;
  logic signed [10:0] w_n1_exp;
  logic               w_n1_zero;

  assign w_in_exp_x = {in_exp[9], in_exp};

  // Leading-zero count above the hidden-bit position; the highest set bit wins.
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i <= 26; i++) begin
      if (in_man[i]) begin
        w_lz = 5'(26 - i);
      end
    end
  end

  // Carry case shifts right keeping the lost bit as sticky, else shift left.
  always_comb begin
    w_n1_zero = (in_man == 28'd0);
    if (in_man[27]) begin
      w_n1_man = {in_man[27:2], in_man[1] | in_man[0]};
      w_n1_exp = w_in_exp_x + c_exp_one;
    end else begin
      w_n1_man = in_man[26:0] << w_lz;
      w_n1_exp = w_in_exp_x - $signed({6'd0, w_lz});
    end
  end

  logic               r_s1_vld;
  logic               r_s1_sign;
  logic               r_s1_zero;
  logic signed [10:0] r_s1_exp;
  logic [26:0]        r_s1_man;

  // Stage 1 register: captures the normalized operand when the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_exp  <= 11'sd0;
      r_s1_man  <= 27'd0;
    end else if (w_advance) begin
      r_s1_vld  <= in_valid;
      r_s1_sign <= in_sign;
      r_s1_zero <= w_n1_zero;
      r_s1_exp  <= w_n1_exp;
      r_s1_man  <= w_n1_man;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 : optional denormalizing shift, then round-to-nearest-even
  // --------------------------------------------------------------------------
  logic [26:0] w_r2_man;
  logic        w_r2_sub;

`ifdef FNORM32_SUBNORM_EN
  logic signed [10:0] w_sub_dist;
  logic [4:0]         w_sub_sh;
  logic [26:0]        w_sub_lost;

  // Tiny values are re-aligned to the subnormal scale; lost bits fold into sticky.
  always_comb begin
    w_sub_dist = c_exp_one - r_s1_exp;
    w_sub_sh   = (w_sub_dist > 11'sd26) ? 5'd26 : w_sub_dist[4:0];
    w_sub_lost = r_s1_man & ~(27'h7FFFFFF << w_sub_sh);
    w_r2_sub   = !r_s1_zero && (r_s1_exp <= c_exp_zero);
    if (w_r2_sub) begin
      w_r2_man = (r_s1_man >> w_sub_sh) | {26'd0, |w_sub_lost};
    end else begin
      w_r2_man = r_s1_man;
    end
  end
`else
  assign w_r2_sub = 1'b0;
  assign w_r2_man = r_s1_man;
`endif

  logic        w_guard;
  logic        w_sticky;
  logic        w_rnd_up;
  logic        w_r2_inexact;
  logic [24:0] w_r2_rnd;

  // Round to nearest, ties to even, on the three bits below the fraction LSB.
  always_comb begin
    w_guard      = w_r2_man[2];
    w_sticky     = |w_r2_man[1:0];
    w_rnd_up     = w_guard & (w_sticky | w_r2_man[3]);
    w_r2_inexact = |w_r2_man[2:0];
    w_r2_rnd     = {1'b0, w_r2_man[26:3]} + {24'd0, w_rnd_up};
  end

  logic               r_s2_vld;
  logic               r_s2_sign;
  logic               r_s2_zero;
  logic               r_s2_sub;
  logic               r_s2_inexact;
  logic signed [10:0] r_s2_exp;
  logic [24:0]        r_s2_man;

  // Stage 2 register: holds the rounded significand and its inexact status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld     <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_zero    <= 1'b0;
      r_s2_sub     <= 1'b0;
      r_s2_inexact <= 1'b0;
      r_s2_exp     <= 11'sd0;
      r_s2_man     <= 25'd0;
    end else if (w_advance) begin
      r_s2_vld     <= r_s1_vld;
      r_s2_sign    <= r_s1_sign;
      r_s2_zero    <= r_s1_zero;
      r_s2_sub     <= w_r2_sub;
      r_s2_inexact <= w_r2_inexact;
      r_s2_exp     <= r_s1_exp;
      r_s2_man     <= w_r2_rnd;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3 : absorb rounding carry, classify range, pack the word
  // --------------------------------------------------------------------------
  logic signed [10:0] w_p3_exp;
  logic [22:0]        w_p3_frac;
  logic [31:0]        w_p3_res;
  logic               w_p3_ovf;
  logic               w_p3_unf;
  logic               w_p3_inexact;

  // Priority: zero, subnormal, overflow, flush-to-zero, then a normal number.
  always_comb begin
    w_p3_res     = 32'd0;
    w_p3_ovf     = 1'b0;
    w_p3_unf     = 1'b0;
    w_p3_inexact = 1'b0;
    if (r_s2_man[24]) begin
      w_p3_exp  = r_s2_exp + c_exp_one;
      w_p3_frac = r_s2_man[23:1];
    end else begin
      w_p3_exp  = r_s2_exp;
      w_p3_frac = r_s2_man[22:0];
    end
    if (r_s2_zero) begin
      w_p3_res = {r_s2_sign, 31'd0};
    end else if (r_s2_sub) begin
      // Bit 23 of the rounded value lands on the exponent LSB, so a carry
      // out of the subnormal range naturally encodes exponent field 1.
      w_p3_res     = {r_s2_sign, 7'd0, r_s2_man[23:0]};
      w_p3_unf     = r_s2_inexact;
      w_p3_inexact = r_s2_inexact;
    end else if (w_p3_exp >= c_exp_inf) begin
      w_p3_res     = {r_s2_sign, 8'hFF, 23'd0};
      w_p3_ovf     = 1'b1;
      w_p3_inexact = 1'b1;
    end else if (w_p3_exp <= c_exp_zero) begin
      w_p3_res     = {r_s2_sign, 31'd0};
      w_p3_unf     = 1'b1;
      w_p3_inexact = 1'b1;
    end else begin
      w_p3_res     = {r_s2_sign, w_p3_exp[7:0], w_p3_frac};
      w_p3_inexact = r_s2_inexact;
    end
  end

  logic [31:0] r_out_res;
  logic        r_out_ovf;
  logic        r_out_unf;
  logic        r_out_inexact;

  // Output register: result and flags hold while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld     <= 1'b0;
      r_out_res     <= 32'd0;
      r_out_ovf     <= 1'b0;
      r_out_unf     <= 1'b0;
      r_out_inexact <= 1'b0;
    end else if (w_advance) begin
      r_out_vld     <= r_s2_vld;
      r_out_res     <= w_p3_res;
      r_out_ovf     <= w_p3_ovf;
      r_out_unf     <= w_p3_unf;
      r_out_inexact <= w_p3_inexact;
    end
  end

  assign out_valid   = r_out_vld;
  assign out_res     = r_out_res;
  assign out_ovf     = r_out_ovf;
  assign out_unf     = r_out_unf;
  assign out_inexact = r_out_inexact;

endmodule
`default_nettype wire

// File: doc/fnorm32.md
FNORM32 -- requirements
Module: fnorm32

Interface
REQ-001 Parameters: none; the datapath is fixed to IEEE-754 binary32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream presents an unpacked result this cycle.
REQ-005 in_ready  output  1  block accepts the input this cycle.
REQ-006 in_sign  input  1  result sign.
REQ-007 in_exp  input  10  biased exponent, two's complement; caller range -128..383.
REQ-008 in_man  input  28  unnormalized magnitude:
- bit27 carry, bit26 hidden, bits25:3 fraction, bits2:0 guard/round/sticky.
- Value = in_man/2^26 * 2^(in_exp-127).
REQ-009 out_valid  output  1  packed result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_res  output  32  packed binary32 result.
REQ-012 out_ovf, out_unf, out_inexact  output  1 each  overflow, underflow and inexact flags, qualified by out_valid.

Function
REQ-013 Three-stage pipeline; latency 3 cycles from accepted input to out_valid with no stalls; throughput 1 per cycle.
REQ-014 Stage 1 (normalize):
- bit27 set: shift right 1, OR the shifted-out bit into sticky, exp+1.
- Otherwise: left-shift by (leading zeros above bit26), exp reduced by the same amount.
- Exponent arithmetic is 11-bit signed and never wraps.
REQ-015 Stage 2 (round): round-to-nearest-even on bits2:0 (guard = bit2, sticky = OR of bits1:0); inexact = OR of bits2:0.
REQ-016 Stage 3 (post-round):
- A rounding carry out of bit26 shifts right 1 and sets exp+1.
- Final exp >= 255 gives signed infinity (exp 0xFF, fraction 0) with ovf=1, inexact=1.
REQ-017 in_man = 0 gives signed zero; all flags 0.
REQ-018 Final exp <= 0 (non-zero value) is handled per REQ-027/028.
REQ-019 Handshake:
- advance = !out_valid || out_ready; in_ready = advance.
- Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-020 While advance = 0, all stage registers, out_res and the flags hold stable.
REQ-021 Bubbles propagate as cleared stage-valid bits; out_res is don't-care when out_valid = 0.
REQ-022 A simultaneous output transfer and input transfer in one cycle is legal; no data is lost or duplicated.

Reset
REQ-023 rst_n low clears all stage-valid bits immediately; out_valid = 0, out_res = 0, all flags = 0.
REQ-024 Reset mid-operation discards in-flight data; the first output after release comes from an input accepted after release.
REQ-025 in_ready is 1 while in reset and in the first cycle after release.

Configuration
REQ-026 The macro FNORM32_SUBNORM_EN selects subnormal support.
REQ-027 Without FNORM32_SUBNORM_EN: final exp <= 0 flushes to signed zero, unf = 1, inexact = 1.
REQ-028 With FNORM32_SUBNORM_EN: final exp <= 0 produces a subnormal.
- Right-shift the mantissa by (1 - exp) before rounding, capped at 26, with sticky collection.
- Exp field 0; unf = 1 when inexact.
- A rounding carry into bit26 yields exp field 1.

Verification
REQ-029 in_man = 28'h4000000, in_exp = 127, sign 0 -> out_res = 32'h3F800000 three cycles later, flags 0.
REQ-030 in_man = 28'h8000000, in_exp = 127 -> 32'h40000000. in_man = 28'h400000C, in_exp = 127 -> 32'h3F800002 with inexact = 1. in_man = 28'h4000004 -> 32'h3F800000 (tie to even) with inexact = 1.
REQ-031 in_man = 28'h7FFFFFF, in_exp = 254 -> 32'h7F800000 with ovf = 1. in_man = 0, sign 1 -> 32'h80000000.
REQ-032 in_man = 28'h4000000, in_exp = 0:
- Without macro -> 32'h00000000, unf = 1.
- With macro -> 32'h00400000, unf = 0.
REQ-033 out_ready held 0 for 5 cycles while 4 inputs are offered:
- in_ready drops once 3 results are held; out_res stays stable.
- All results emerge in order once out_ready rises.
REQ-034 rst_n asserted with 2 results in flight -> out_valid = 0 asynchronously; no stale result after release.
